// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared types and constants for the SDRAM port arbiter
package arb_pkg;

  localparam int ADDR_W                 = 26;
  localparam int DATA_W                 = 32;
  localparam int CNT_W                  = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } arb_state_e;

  // Round-robin choice: a read wins unless a write is also pending and the read was served last.
  function automatic logic pick_read(input logic rd, input logic wr, input logic last_was_rd);
    return rd && (!wr || !last_was_rd);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - client request/response port of the SDRAM port arbiter
interface sdram_port_arbiter_if;
  import arb_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_valid, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_valid, rd_data, wr_gnt
  );

endinterface

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - read-wait cycle counter with rollover detect
module arb_timeout_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] rollover_value,
  output logic             rollover
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the cycle whose increment would bring the count to the full limit.
  assign rollover = enable && (count == rollover_value);

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin read/write arbiter in front of a single SDRAM command port
module sdram_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sdram_port_arbiter_if.slave  bus,
  input  logic                 err_clear,
  input  logic                 sdram_datareadvalid,
  input  logic [DATA_W-1:0]    data_sdram,
  output logic                 sdram_read_en,
  output logic                 sdram_write_en,
  output logic [ADDR_W-1:0]    address_sdram,
  output logic [DATA_W-1:0]    writeData_sdram,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [CNT_W-1:0] ROLL_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e state;
  logic       last_rd;
  logic       cnt_clear;
  logic       cnt_en;
  logic       cnt_roll;
  logic       timeout_hit;

  assign cnt_clear   = (state == RD_ISSUE);
  assign cnt_en      = (state == RD_WAIT) && !sdram_datareadvalid;
  assign timeout_hit = cnt_roll;

  arb_timeout_counter u_timeout (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (cnt_clear),
    .enable         (cnt_en),
    .rollover_value (ROLL_VALUE),
    .rollover       (cnt_roll)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state           <= IDLE;
      last_rd         <= 1'b1;
      bus.rd_gnt      <= 1'b0;
      bus.wr_gnt      <= 1'b0;
      bus.rd_valid    <= 1'b0;
      bus.rd_data     <= '0;
      sdram_read_en   <= 1'b0;
      sdram_write_en  <= 1'b0;
      address_sdram   <= '0;
      writeData_sdram <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      bus.rd_gnt     <= 1'b0;
      bus.wr_gnt     <= 1'b0;
      bus.rd_valid   <= 1'b0;
      sdram_read_en  <= 1'b0;
      sdram_write_en <= 1'b0;

      // A timeout landing together with err_clear keeps the flag set.
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.rd_req || bus.wr_req) begin
            busy <= 1'b1;
            if (pick_read(bus.rd_req, bus.wr_req, last_rd)) begin
              state         <= RD_ISSUE;
              last_rd       <= 1'b1;
              bus.rd_gnt    <= 1'b1;
              sdram_read_en <= 1'b1;
              address_sdram <= bus.rd_addr;
            end else begin
              state           <= WR_ISSUE;
              last_rd         <= 1'b0;
              bus.wr_gnt      <= 1'b1;
              sdram_write_en  <= 1'b1;
              address_sdram   <= bus.wr_addr;
              writeData_sdram <= bus.wr_data;
            end
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (sdram_datareadvalid) begin
            bus.rd_data  <= data_sdram;
            bus.rd_valid <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else if (timeout_hit) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        WR_ISSUE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        err_clear;
  logic        sdram_datareadvalid;
  logic [31:0] data_sdram;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;
  int both_cnt = 0;
  int k;
  int ngnt;
  logic [3:0] order;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter #(.TIMEOUT_CYCLES(255)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .bus                 (bus),
    .err_clear           (err_clear),
    .sdram_datareadvalid (sdram_datareadvalid),
    .data_sdram          (data_sdram),
    .sdram_read_en       (sdram_read_en),
    .sdram_write_en      (sdram_write_en),
    .address_sdram       (address_sdram),
    .writeData_sdram     (writeData_sdram),
    .busy                (busy),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_valid) rv_cnt++;
    if (sdram_read_en && sdram_write_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    err_clear = 1'b0; sdram_datareadvalid = 1'b0; data_sdram = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_rd_gnt", bus.rd_gnt, 0);
    chk("rst_wr_gnt", bus.wr_gnt, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_en", {sdram_read_en, sdram_write_en}, 0);
    chk("rst_addr", address_sdram, 0);
    chk("rst_wdata", writeData_sdram, 0);
    chk("rst_busy_err", {busy, timeout_err}, 0);
    n_rst = 1'b1;

    // single read with strobe three cycles into the wait
    bus.rd_req = 1'b1; bus.rd_addr = 26'h0000100;
    @(negedge clk);
    chk("rd_gnt", bus.rd_gnt, 1);
    chk("rd_en", sdram_read_en, 1);
    chk("rd_addr", address_sdram, 32'h100);
    chk("rd_busy", busy, 1);
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_en_one", {sdram_read_en, bus.rd_gnt}, 0);
    @(negedge clk);
    @(negedge clk);
    sdram_datareadvalid = 1'b1; data_sdram = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_data", bus.rd_data, 32'hDEADBEEF);
    chk("rd_idle", busy, 0);
    sdram_datareadvalid = 1'b0;
    @(negedge clk);
    chk("rd_valid_one", bus.rd_valid, 0);

    // single write
    bus.wr_req = 1'b1; bus.wr_addr = 26'h0000200; bus.wr_data = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", {bus.wr_gnt, sdram_write_en, sdram_read_en}, 3'b110);
    chk("wr_addr", address_sdram, 32'h200);
    chk("wr_data", writeData_sdram, 32'h12345678);
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("wr_en_one", sdram_write_en, 0);
    chk("wr_idle", busy, 0);
    chk("wr_addr_hold", address_sdram, 32'h200);
    chk("wr_data_hold", writeData_sdram, 32'h12345678);

    // both requesters held from reset: W,R,W,R
    do_reset();
    n_rst = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 26'h3A0;
    bus.wr_req = 1'b1; bus.wr_addr = 26'h3B0; bus.wr_data = 32'hCAFE0000;
    order = '0; ngnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.wr_gnt) begin order = {order[2:0], 1'b1}; ngnt++; end
      if (bus.rd_gnt) begin order = {order[2:0], 1'b0}; ngnt++; end
      if (sdram_read_en) begin sdram_datareadvalid = 1'b1; data_sdram = 32'hA0 + ngnt; end
      if (bus.rd_valid) sdram_datareadvalid = 1'b0;
      if (ngnt >= 4) begin bus.rd_req = 1'b0; bus.wr_req = 1'b0; end
      if (ngnt >= 4 && !busy && !sdram_datareadvalid) break;
    end
    chk("rr_count", ngnt, 4);
    chk("rr_order", order, 4'b1010);
    chk("rr_last_data", bus.rd_data, 32'hA4);

    // read timeout, then sticky flag and clear
    bus.rd_req = 1'b1; bus.rd_addr = 26'h2AB;
    @(negedge clk);
    chk("to_rd_en", sdram_read_en, 1);
    bus.rd_req = 1'b0;
    k = 0;
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, 256);
    chk("to_valid", bus.rd_valid, 1);
    chk("to_data", bus.rd_data, 0);
    chk("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    chk("to_clear", timeout_err, 0);

    // timeout coinciding with err_clear keeps the flag
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (255) @(negedge clk);
    chk("to_race_pre", timeout_err, 0);
    @(negedge clk);
    chk("to_race", timeout_err, 1);
    @(negedge clk);
    chk("to_race_after", timeout_err, 0);
    err_clear = 1'b0;

    // reset in RD_WAIT, then a late strobe
    bus.rd_req = 1'b1; bus.rd_addr = 26'h155;
    @(negedge clk);
    chk("rw_rd_en", sdram_read_en, 1);
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rw_wait_busy", busy, 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rw_rst_addr", address_sdram, 0);
    chk("rw_rst_out", {busy, sdram_read_en, bus.rd_valid}, 0);
    n_rst = 1'b1;
    sdram_datareadvalid = 1'b1; data_sdram = 32'h5555AAAA;
    @(negedge clk);
    chk("rw_no_valid", {bus.rd_valid, busy}, 0);
    @(negedge clk);
    chk("rw_no_valid2", {bus.rd_valid, busy}, 0);
    chk("rw_rd_data", bus.rd_data, 0);
    sdram_datareadvalid = 1'b0;

    // strobe during WR_ISSUE is ignored
    bus.wr_req = 1'b1; bus.wr_addr = 26'h3C0; bus.wr_data = 32'h0F0F0F0F;
    @(negedge clk);
    chk("wv_gnt", {bus.wr_gnt, sdram_write_en}, 2'b11);
    bus.wr_req = 1'b0;
    sdram_datareadvalid = 1'b1; data_sdram = 32'h77;
    @(negedge clk);
    chk("wv_no_valid", {bus.rd_valid, busy}, 0);
    @(negedge clk);
    chk("wv_idle", {bus.rd_valid, busy, sdram_read_en}, 0);
    chk("wv_rd_data", bus.rd_data, 0);
    sdram_datareadvalid = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("valid_pulses", rv_cnt, 5);
    chk("both_en", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum RD_WAIT cycles before a read is abandoned.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-low.
REQ-004 rd_req  input  1  read request, level; held until rd_gnt.
REQ-005 rd_addr  input  26  read address, sampled with rd_gnt.
REQ-006 wr_req  input  1  write request, level; held until wr_gnt.
REQ-007 wr_addr  input  26  write address, sampled with wr_gnt.
REQ-008 wr_data  input  32  write data, sampled with wr_gnt.
REQ-009 err_clear  input  1  clears timeout_err.
REQ-010 sdram_datareadvalid  input  1  SDRAM read-data-valid strobe.
REQ-011 data_sdram  input  32  SDRAM read data.
REQ-012 rd_gnt / wr_gnt  output  1 each  one-cycle acceptance pulses.
REQ-013 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 rd_data  output  32  returned read data.
REQ-015 sdram_read_en / sdram_write_en  output  1 each  SDRAM command strobes.
REQ-016 address_sdram  output  26  SDRAM address.
REQ-017 writeData_sdram  output  32  SDRAM write data.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 timeout_err  output  1  sticky read-timeout flag.

Function
REQ-020 The block SHALL use a state machine with states IDLE, RD_ISSUE, RD_WAIT and WR_ISSUE, and every output SHALL be registered.
REQ-021 In IDLE, a sole rd_req SHALL go to RD_ISSUE and a sole wr_req SHALL go to WR_ISSUE.
REQ-022 When rd_req and wr_req are high together in IDLE, the grant SHALL go to the requester not served last (round-robin); after reset, read is treated as served last, so write wins first.
REQ-023 The grant pulse (rd_gnt or wr_gnt) SHALL be high in the first cycle of RD_ISSUE or WR_ISSUE, and address and data SHALL be latched on that entry edge.
REQ-024 In RD_ISSUE, sdram_read_en SHALL be high for exactly one cycle with address_sdram equal to the latched rd_addr; the next state SHALL be RD_WAIT.
REQ-025 In RD_WAIT, when sdram_datareadvalid is high, rd_data SHALL capture data_sdram, rd_valid SHALL pulse on the next cycle, and the next state SHALL be IDLE.
REQ-026 The RD_WAIT counter SHALL be 8 bits wide and SHALL clear on RD_WAIT entry.
REQ-027 If the RD_WAIT counter reaches TIMEOUT_CYCLES with no valid strobe: timeout_err SHALL be set, rd_valid SHALL pulse with rd_data = 0, and the next state SHALL be IDLE.
REQ-028 In WR_ISSUE, sdram_write_en SHALL be high for exactly one cycle with the latched address and data; the next state SHALL be IDLE.
REQ-029 sdram_read_en and sdram_write_en SHALL never be high in the same cycle.
REQ-030 sdram_datareadvalid SHALL be ignored outside RD_WAIT.
REQ-031 A request arriving while busy SHALL wait; no request SHALL be lost or granted twice.
REQ-032 Latency: a request seen in IDLE at cycle N SHALL produce its gnt and command at N+1; rd_valid SHALL follow the valid strobe by 1 cycle.
REQ-033 Back-to-back: IDLE SHALL be occupied for at least one cycle between transactions.
REQ-034 err_clear SHALL clear timeout_err; a timeout in the same cycle as err_clear SHALL win, leaving timeout_err = 1.
REQ-035 address_sdram and writeData_sdram SHALL hold their last values between commands.

Reset
REQ-036 While n_rst = 0 at a clock edge, the state SHALL become IDLE, all outputs and the counter SHALL become 0, and the round-robin pointer SHALL favour write.
REQ-037 Reset mid-transaction SHALL abandon it, with no rd_valid and no further command strobe.

Structure
REQ-038 Shared package arb_pkg SHALL hold the state enum type and the TIMEOUT_CYCLES default.
REQ-039 One sub-module, arb_timeout_counter (clear, enable, rollover value, rollover flag), SHALL implement the RD_WAIT counter.

Verification
REQ-040 Read of 0x0000100 with valid strobe 3 cycles later carrying 0xDEADBEEF -> read_en pulse 1 cycle, rd_valid 1 cycle, rd_data = 0xDEADBEEF.
REQ-041 Write of 0x0000200 / 0x12345678 -> wr_gnt and write_en in the same cycle, bus shows 0x0000200 / 0x12345678.
REQ-042 rd_req and wr_req held high from reset for 4 transactions -> order W,R,W,R, never both enables high.
REQ-043 Read with no valid strobe -> timeout_err = 1 after 255 RD_WAIT cycles, rd_data = 0; err_clear then clears it.
REQ-044 n_rst low during RD_WAIT, then valid strobe -> no rd_valid, state IDLE, outputs 0.
REQ-045 Valid strobe in IDLE or WR_ISSUE -> no rd_valid and no state change.
